// File: rtl/sarray_rd_slave.sv
// Read-channel responder for the systolic-array load path: in-order request queue with
// fixed latency, multi-beat bursts and address-derived data, all outputs registered.
module sarray_rd_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 8,
    parameter int LATENCY    = 4,
    parameter int BEATS      = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ar_valid_i,
    output logic                         ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]        ar_addr_i,
    output logic                         r_valid_o,
    input  logic                         r_ready_i,
    output logic [DATA_WIDTH-1:0]        r_data_o,
    output logic                         r_last_o,
    input  logic                         r_stall_i,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding_o
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LANES  = DATA_WIDTH / 32;

    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [LAT_W-1:0]      lat_q  [DEPTH];
    logic [LAT_W-1:0]      lat_d  [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  r_valid_q, r_valid_d;
    logic                  r_last_q, r_last_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  ar_ready_q, ar_ready_d;
    logic                  push, hs, pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Lane k of beat b carries base + 4*(b*LANES + k), wrapping at 32 bits.
    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [31:0] base,
                                                        input logic [BEAT_W-1:0] b);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        for (int k = 0; k < LANES; k++) begin
            d[32*k +: 32] = base + 32'(4 * (int'(b) * LANES + k));
        end
        return d;
    endfunction

    always_comb begin
        push = ar_valid_i && ar_ready_q;
        hs   = r_valid_q && r_ready_i;
        pop  = hs && r_last_q;

        for (int i = 0; i < DEPTH; i++) begin
            addr_d[i] = addr_q[i];
            lat_d[i]  = (lat_q[i] != '0) ? lat_q[i] - LAT_W'(1) : '0;
        end
        if (push) begin
            addr_d[tail_q] = ar_addr_i;
            lat_d[tail_q]  = LAT_INIT;
        end

        tail_d = push ? next_ptr(tail_q) : tail_q;
        head_d = pop ? next_ptr(head_q) : head_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop)     beat_d = '0;
        else if (hs) beat_d = beat_q + BEAT_W'(1);
        else         beat_d = beat_q;

        // A presented beat is held until accepted; new beats need an eligible head and no stall.
        // Popping always leaves one idle cycle before the next request presents.
        if (r_valid_q && !r_ready_i) begin
            r_valid_d = 1'b1;
        end else begin
            r_valid_d = !pop && (count_d != '0) && (lat_d[head_q] == '0) && !r_stall_i;
        end

        r_data_d   = r_valid_d ? beat_data(32'(addr_d[head_q]), beat_d) : '0;
        r_last_d   = r_valid_d && (beat_d == LAST_BEAT);
        ar_ready_d = (count_d < DEPTH_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                lat_q[i]  <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            beat_q     <= '0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
            ar_ready_q <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                lat_q[i]  <= lat_d[i];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            beat_q     <= beat_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_data_q   <= r_data_d;
            ar_ready_q <= ar_ready_d;
        end
    end

    assign ar_ready_o    = ar_ready_q;
    assign r_valid_o     = r_valid_q;
    assign r_data_o      = r_data_q;
    assign r_last_o      = r_last_q;
    assign outstanding_o = count_q;
endmodule
